// File: rtl/instruction_fetch_if.sv
// Bundle between the IF stage and its neighbours: ID redirect/stall controls,
// the loader write port, and the IF/ID register outputs feeding decode.
interface instruction_fetch_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
);
  logic               i_enable;
  logic               i_stall;
  logic               i_jump;
  logic               i_branch_taken;
  logic [NB_DATA-1:0] i_target;
  logic               i_wr_en;
  logic [NB_ADDR-1:0] i_wr_addr;
  logic [NB_DATA-1:0] i_wr_data;
  logic [NB_DATA-1:0] o_pc;
  logic [NB_DATA-1:0] o_pc_plus4;
  logic [NB_DATA-1:0] o_instr;
  logic [5:0]         o_opcode;
  logic [5:0]         o_funct;
  logic               o_valid;
  logic               o_halt;

  // o_valid qualifies the IF/ID word; there is no ready, downstream holds via i_stall.
  modport slave (
    input  i_enable, i_stall, i_jump, i_branch_taken, i_target,
           i_wr_en, i_wr_addr, i_wr_data,
    output o_pc, o_pc_plus4, o_instr, o_opcode, o_funct, o_valid, o_halt
  );

  modport master (
    output i_enable, i_stall, i_jump, i_branch_taken, i_target,
           i_wr_en, i_wr_addr, i_wr_data,
    input  o_pc, o_pc_plus4, o_instr, o_opcode, o_funct, o_valid, o_halt
  );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC, word-addressed instruction memory with a loader write
// port, and the IF/ID register with redirect flush, stall and HALT freeze.
module instruction_fetch #(
  parameter int                 NB_DATA  = 32,
  parameter int                 NB_ADDR  = 8,
  parameter logic [NB_DATA-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                i_rst,
  instruction_fetch_if.slave  if_bus
);
  localparam int DEPTH = 1 << NB_ADDR;

  logic [NB_DATA-1:0] r_mem [0:DEPTH-1];
  logic [NB_DATA-1:0] r_pc;
  logic [NB_DATA-1:0] r_if_pc;
  logic [NB_DATA-1:0] r_instr;
  logic               r_valid;
  logic               r_halt;

  logic [NB_DATA-1:0] w_fetch;
  logic               w_redirect;
  logic               w_fetch_is_halt;
  logic [1:0]         w_unused_target_bits;

  // Upper PC bits are dropped, so fetch addresses wrap modulo the depth.
  assign w_fetch         = r_mem[r_pc[NB_ADDR+1:2]];
  assign w_redirect      = if_bus.i_jump | if_bus.i_branch_taken;
  assign w_fetch_is_halt = (w_fetch[NB_DATA-1:NB_DATA-6] == 6'b111111);
  assign w_unused_target_bits = if_bus.i_target[1:0];

  // Memory is never reset so a loaded program survives i_rst.
  always_ff @(posedge clk) begin
    if (if_bus.i_wr_en) begin
      r_mem[if_bus.i_wr_addr] <= if_bus.i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_pc    <= RESET_PC;
      r_if_pc <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_halt  <= 1'b0;
    end else if (if_bus.i_enable && !r_halt) begin
      if (w_redirect) begin
        // Flush the wrong-path fetch; a HALT arriving this edge is squashed too.
        r_pc    <= {if_bus.i_target[NB_DATA-1:2], 2'b00};
        r_instr <= '0;
        r_valid <= 1'b0;
      end else if (!if_bus.i_stall) begin
        r_if_pc <= r_pc;
        r_instr <= w_fetch;
        r_valid <= 1'b1;
        r_halt  <= w_fetch_is_halt;
        r_pc    <= r_pc + NB_DATA'(4);
      end
    end
  end

  assign if_bus.o_pc       = r_if_pc;
  assign if_bus.o_pc_plus4 = r_if_pc + NB_DATA'(4);
  assign if_bus.o_instr    = r_instr;
  assign if_bus.o_opcode   = r_instr[NB_DATA-1:NB_DATA-6];
  assign if_bus.o_funct    = r_instr[5:0];
  assign if_bus.o_valid    = r_valid;
  assign if_bus.o_halt     = r_halt;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: reference model feeds an expected queue each
// cycle, outputs are popped and compared one edge later, plus directed checks.
module tb_instruction_fetch;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_if #(.NB_DATA(32), .NB_ADDR(8)) bus ();

  instruction_fetch #(.NB_DATA(32), .NB_ADDR(8), .RESET_PC(32'h0)) dut (
    .clk    (clk),
    .i_rst  (rst),
    .if_bus (bus)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [65:0] exp_q[$];

  // reference model state
  logic [31:0] m_mem [0:255];
  logic [31:0] m_pc, m_ifpc, m_instr;
  logic        m_valid, m_halt;

  task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    rst                = 1'b0;
    bus.i_enable       = 1'b1;
    bus.i_stall        = 1'b0;
    bus.i_jump         = 1'b0;
    bus.i_branch_taken = 1'b0;
    bus.i_target       = '0;
    bus.i_wr_en        = 1'b0;
    bus.i_wr_addr      = '0;
    bus.i_wr_data      = '0;
  endtask

  // Predict the edge from the current inputs, clock it, then compare.
  task automatic step(input bit do_check);
    logic [31:0] fetch;
    logic [65:0] e;
    fetch = m_mem[m_pc[9:2]];
    if (rst) begin
      m_pc = 32'h0; m_ifpc = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_halt = 1'b0;
    end else if (bus.i_enable && !m_halt) begin
      if (bus.i_jump || bus.i_branch_taken) begin
        m_pc = {bus.i_target[31:2], 2'b00};
        m_instr = 32'h0;
        m_valid = 1'b0;
      end else if (!bus.i_stall) begin
        m_ifpc  = m_pc;
        m_instr = fetch;
        m_valid = 1'b1;
        m_halt  = (fetch[31:26] == 6'h3f);
        m_pc    = m_pc + 32'd4;
      end
    end
    if (bus.i_wr_en) m_mem[bus.i_wr_addr] = bus.i_wr_data;
    if (do_check) exp_q.push_back({m_halt, m_valid, m_ifpc, m_instr});
    @(posedge clk);
    #1;
    if (do_check) begin
      e = exp_q.pop_front();
      check_eq("ifid", {bus.o_halt, bus.o_valid, bus.o_pc, bus.o_instr}, e);
      check_eq("pc_plus4", 66'(bus.o_pc_plus4), 66'(e[63:32] + 32'd4));
      check_eq("opcode", 66'(bus.o_opcode), 66'(e[31:26]));
      check_eq("funct", 66'(bus.o_funct), 66'(e[5:0]));
    end
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [31:0] data, input bit do_check);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_addr = addr;
    bus.i_wr_data = data;
    step(do_check);
    bus.i_wr_en   = 1'b0;
  endtask

  task automatic redirect(input bit is_jump, input logic [31:0] target);
    bus.i_jump         = is_jump;
    bus.i_branch_taken = !is_jump;
    bus.i_target       = target;
    step(1'b1);
    bus.i_jump         = 1'b0;
    bus.i_branch_taken = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    bus.i_enable = 1'b0;
    @(posedge clk); #1;

    // program loaded while the stage is disabled
    load_word(8'd0,   32'h20010005, 1'b0);
    load_word(8'd1,   32'h20020003, 1'b0);
    load_word(8'd2,   32'h00221820, 1'b0);
    load_word(8'd3,   32'hAC030000, 1'b0);
    load_word(8'd4,   32'h8C040004, 1'b0);
    load_word(8'd5,   32'hAAAA0005, 1'b0);
    load_word(8'd255, 32'h012A4020, 1'b0);

    // reset state
    rst = 1'b1;
    step(1'b1);
    check_eq("reset_valid", 66'(bus.o_valid), 66'(0));
    rst = 1'b0;
    bus.i_enable = 1'b1;

    // sequential fetch
    step(1'b1);
    check_eq("seq_pc0", 66'(bus.o_pc), 66'(32'h0));
    check_eq("seq_instr0", 66'(bus.o_instr), 66'(32'h20010005));
    step(1'b1);
    check_eq("seq_pc4", 66'(bus.o_pc), 66'(32'h4));

    // two stall cycles hold o_pc=4
    bus.i_stall = 1'b1;
    step(1'b1);
    step(1'b1);
    check_eq("stall_pc", 66'(bus.o_pc), 66'(32'h4));
    check_eq("stall_instr", 66'(bus.o_instr), 66'(32'h20020003));
    bus.i_stall = 1'b0;
    step(1'b1);
    check_eq("resume_pc", 66'(bus.o_pc), 66'(32'h8));
    check_eq("add_opcode", 66'(bus.o_opcode), 66'(6'h00));
    check_eq("add_funct", 66'(bus.o_funct), 66'(6'h20));

    // jump with unaligned target: bubble, then word 4
    redirect(1'b1, 32'h00000013);
    check_eq("jump_bubble_valid", 66'(bus.o_valid), 66'(0));
    check_eq("jump_bubble_instr", 66'(bus.o_instr), 66'(0));
    step(1'b1);
    check_eq("jump_pc", 66'(bus.o_pc), 66'(32'h10));
    check_eq("jump_instr", 66'(bus.o_instr), 66'(32'h8C040004));

    // taken branch beats a simultaneous stall; then wrap past word 255
    bus.i_stall = 1'b1;
    redirect(1'b0, 32'h000003FC);
    bus.i_stall = 1'b0;
    check_eq("br_stall_bubble", 66'(bus.o_valid), 66'(0));
    step(1'b1);
    check_eq("wrap_pc3fc", 66'(bus.o_pc), 66'(32'h3FC));
    step(1'b1);
    check_eq("wrap_pc400", 66'(bus.o_pc), 66'(32'h400));
    check_eq("wrap_instr", 66'(bus.o_instr), 66'(32'h20010005));

    // write to the word being fetched: old value is captured
    redirect(1'b1, 32'h00000014);
    load_word(8'd5, 32'h12345678, 1'b1);
    check_eq("rbw_old", 66'(bus.o_instr), 66'(32'hAAAA0005));
    redirect(1'b1, 32'h00000014);
    step(1'b1);
    check_eq("rbw_new", 66'(bus.o_instr), 66'(32'h12345678));

    // HALT at word 2
    load_word(8'd2, 32'hFC000000, 1'b1);
    rst = 1'b1; step(1'b1); rst = 1'b0;
    step(1'b1); step(1'b1); step(1'b1);
    check_eq("halt_set", 66'(bus.o_halt), 66'(1));
    check_eq("halt_pc", 66'(bus.o_pc), 66'(32'h8));
    bus.i_enable = 1'b0; step(1'b1);
    bus.i_enable = 1'b1; bus.i_stall = 1'b1; step(1'b1);
    bus.i_stall = 1'b0;
    redirect(1'b1, 32'h00000010);
    step(1'b1);
    check_eq("halt_frozen_pc", 66'(bus.o_pc), 66'(32'h8));
    check_eq("halt_frozen_instr", 66'(bus.o_instr), 66'(32'hFC000000));
    rst = 1'b1; step(1'b1); rst = 1'b0;
    check_eq("halt_cleared", 66'(bus.o_halt), 66'(0));
    step(1'b1);
    check_eq("refetch_pc", 66'(bus.o_pc), 66'(32'h0));

    // redirect on the edge that would load HALT squashes it
    step(1'b1);
    redirect(1'b1, 32'h00000000);
    check_eq("halt_squashed", 66'(bus.o_halt), 66'(0));
    load_word(8'd2, 32'h00221820, 1'b1);

    // reset while stalled at PC=0x0C
    rst = 1'b1; step(1'b1); rst = 1'b0;
    step(1'b1); step(1'b1); step(1'b1);
    bus.i_stall = 1'b1;
    step(1'b1);
    rst = 1'b1; step(1'b1); rst = 1'b0;
    check_eq("rst_stall_valid", 66'(bus.o_valid), 66'(0));
    check_eq("rst_stall_instr", 66'(bus.o_instr), 66'(0));
    bus.i_stall = 1'b0;
    step(1'b1);
    check_eq("rst_refetch", 66'(bus.o_instr), 66'(32'h20010005));

    // randomized mix against the model
    for (int i = 0; i < 200; i++) begin
      logic [31:0] tgt;
      rst                = ($urandom_range(0, 19) == 0);
      bus.i_enable       = ($urandom_range(0, 7) != 0);
      bus.i_stall        = ($urandom_range(0, 3) == 0);
      bus.i_jump         = ($urandom_range(0, 9) == 0);
      bus.i_branch_taken = ($urandom_range(0, 9) == 0);
      tgt = ($urandom_range(0, 6) == 6) ? 32'h3FC : 32'($urandom_range(0, 5)) << 2;
      bus.i_target       = tgt | 32'($urandom_range(0, 3));
      bus.i_wr_en        = ($urandom_range(0, 7) == 0);
      bus.i_wr_addr      = 8'($urandom_range(0, 5));
      bus.i_wr_data      = $urandom();
      step(1'b1);
    end
    drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
